// File: rtl/fraction_multiplier_param.sv
// Sequential shift-add multiplier for signed Q1.(N-1) fractions.
// One product per start; the load edge plus N CALC iterations give N+1 clocks per product.
// The result is {A[N-2:0], B}. This is the 2N-bit product with its redundant sign bit dropped.
// The only unrepresentable case is -1 x -1. Ovf flags it and, when SAT=1, the result is clamped.
module fraction_multiplier_param #(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           St,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic [2*N-2:0] Product,
  output logic           Done,
  output logic           Busy,
  output logic           Ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST_COUNT = CW'(N - 1);
  localparam logic [N-1:0]   MIN_NEG    = {1'b1, {(N-1){1'b0}}};
  localparam logic [2*N-2:0] MAX_POS    = {1'b0, {(2*N-2){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic [N:0]     a_ext;
  logic [N:0]     m_ext;
  logic [N:0]     psum;
  logic [2*N-2:0] raw_product;

  // Partial sum in N+1 bits. The last iteration subtracts because the multiplier MSB has negative weight.
  always_comb begin
    a_ext = {a_q[N-1], a_q};
    m_ext = {m_q[N-1], m_q};
    psum  = a_ext;
    if (b_q[0]) begin
      if (count_q == LAST_COUNT) begin
        psum = a_ext - m_ext;
      end else begin
        psum = a_ext + m_ext;
      end
    end
  end

  // Next-state, datapath and status update.
  // Busy clears one cycle after DONE is entered, so it covers the load edge through edge k+N.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (St) begin
          a_d     = '0;
          b_d     = Mplier;
          m_d     = Mcand;
          count_d = '0;
          ovf_d   = (Mplier == MIN_NEG) && (Mcand == MIN_NEG);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // Arithmetic right shift of {P, B}. P[0] moves into B's MSB and P's sign fills A's MSB.
        a_d     = psum[N:1];
        b_d     = {psum[0], b_q[N-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        if (!St) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any run in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are decoded from registers only.
  // The saturated value stays visible in IDLE until the next start.
  always_comb begin
    raw_product = {a_q[N-2:0], b_q};
    Product     = raw_product;
    if (SAT && ovf_q && (state_q != CALC)) begin
      Product = MAX_POS;
    end
    Done = (state_q == DONE);
    Busy = busy_q;
    Ovf  = ovf_q;
  end

endmodule
